board_ram_arbiter: RTL and testbench
====================================

Name: board_ram_arbiter

Overview:
- Shares the single-port board RAM (8-bit address, 6-bit cell colour) between up to four requesters: collision check, add-to-RAM, draw-RAM and the line-clear engine.
- Grants the RAM round-robin with burst ownership and optional lock against preemption.
- Returns read data with per-requester valid strobes aligned to the RAM read latency.
- Sits between the game control FSM's submodules and the board RAM instance, replacing the ad-hoc per-state address mux.

Parameters:
- N_REQ, 4, number of requesters (2..4).
- READ_LATENCY, 2, clock cycles from address presented to ram_q valid (1..3).
- MAX_BURST, 16, consecutive granted cycles before an unlocked owner may be preempted (1..255).
- BOARD_CELLS, 200, number of valid cell addresses (10 x 20 board).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester request; held high for the whole burst
- lock  in  N_REQ  per-requester no-preempt flag; sampled only while that requester owns the RAM
- addr  in  N_REQ*8  flattened cell addresses; requester i uses bits [8i+7:8i]
- wdata  in  N_REQ*6  flattened write data; requester i uses bits [6i+5:6i]
- wren  in  N_REQ  per-requester write enable
- gnt  out  N_REQ  one-hot registered grant
- rvalid  out  N_REQ  one-cycle strobe: rdata carries that requester's read result
- rdata  out  6  ram_q passed through, shared by all requesters
- ram_addr  out  8  to board RAM
- ram_data  out  6  to board RAM
- ram_wren  out  1  to board RAM
- ram_q  in  6  from board RAM
- busy  out  1  high while any grant is held

Behaviour:
- Reset (asynchronous, reset_n low):
  - gnt=0, rvalid=0, busy=0, state=IDLE.
  - Round-robin pointer=0, burst counter=0, read pipeline cleared.
  - Any in-flight read is discarded; no rvalid appears after reset releases.
- States: IDLE and OWN.
- IDLE:
  - ram_wren=0 and ram_addr=0.
  - If any req is high, choose the first requester at or after the pointer, wrapping modulo N_REQ.
  - At the next edge, gnt becomes one-hot on the chosen requester, state goes to OWN and the burst counter is set to 1.
  - With no request, state stays IDLE.
- OWN, access path:
  - ram_addr, ram_data and ram_wren are driven combinationally from the owner's addr, wdata and wren, selected by the registered owner index.
  - Every cycle with req[owner]=1 is one RAM access.
  - The burst counter increments each OWN cycle and saturates at 255.
- OWN, release:
  - If req[owner] falls, the access is not performed that cycle (ram_wren forced to 0).
  - At the next edge gnt clears, state goes to IDLE and the pointer becomes owner+1 mod N_REQ.
- OWN, preemption:
  - Applies when lock[owner]=0, the burst counter is at or above MAX_BURST and another req is high.
  - The current cycle's access completes.
  - At the next edge gnt clears, state goes to IDLE and the pointer becomes owner+1.
  - The owner's still-high req re-competes from IDLE.
  - With lock[owner]=1 the owner is never preempted.
- Handover: at least one IDLE cycle separates two owners, so the minimum handover is 2 cycles from req drop to the new gnt.
- Read return:
  - A cycle with gnt[i]=1, req[i]=1 and wren[i]=0 pushes (valid, i) into a READ_LATENCY-deep shift register.
  - rvalid[i] pulses exactly READ_LATENCY cycles later, coinciding with ram_q valid.
  - Reads issued just before release or preemption still return their rvalid after the grant is gone.
  - Writes never produce rvalid.
- Simultaneous events:
  - Several reqs rising in the same IDLE cycle are resolved purely by the pointer.
  - req and lock changing in the same cycle: lock is evaluated with that cycle's value.
- busy equals (state==OWN).
- Widths: the pointer is 2 bits. Requester indices at or above N_REQ are never granted; their inputs are ignored.

Optional Feature:
- Macro ARB_BOUNDS_CHECK_EN.
- When defined:
  - Any granted access with addr at or above BOARD_CELLS is suppressed: ram_wren=0 and ram_addr=0.
  - A read to such an address still pushes the pipeline, but its rvalid comes with rdata forced to 0.
  - Added output port bound_err (1 bit) pulses for one cycle on the offending access. It resets to 0.
- When undefined: no bound_err port, and addresses pass through unchecked.

Test Plan:
- Single requester: req[1]=1, wren=0, addr=8'd37 for 3 cycles -> gnt[1] rises 1 cycle after req; ram_addr=37 during OWN; three rvalid[1] pulses, each 2 cycles after its access.
- Contention: req[0] and req[2] rise together with pointer=0 -> requester 0 granted first; after req[0] drops, one IDLE cycle, then gnt[2]; pointer ends at 3.
- Preemption: MAX_BURST=4, req[3] held with lock=0 and req[1] asserted at cycle 2 -> gnt[3] drops after its 4th access; gnt[1] rises 2 cycles later.
- Lock: same as the preemption test with lock[3]=1 -> gnt[3] held for all 20 cycles; req[1] is granted only after req[3] drops.
- Reset mid-read: read issued, then reset_n pulsed low one cycle later -> gnt, rvalid and busy go to 0 immediately; no rvalid after release.
- With ARB_BOUNDS_CHECK_EN defined: write to addr=8'd200 -> ram_wren stays 0 and bound_err pulses once; write to addr=8'd199 -> ram_wren=1.

Source files
------------

// File: rtl/board_ram_arbiter.sv
`default_nettype none
// ============================================================================
// board_ram_arbiter : round-robin burst arbiter for the shared board RAM
// Optional macro ARB_BOUNDS_CHECK_EN : suppress out-of-board accesses, add bound_err
// Rev 1.0
// ============================================================================
module board_ram_arbiter #(
  parameter int N_REQ        = 4,
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 16,
  parameter int BOARD_CELLS  = 200
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   lock,
  input  logic [N_REQ*8-1:0] addr,
  input  logic [N_REQ*6-1:0] wdata,
  input  logic [N_REQ-1:0]   wren,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rvalid,
  output logic [5:0]         rdata,
  output logic [7:0]         ram_addr,
  output logic [5:0]         ram_data,
  output logic               ram_wren,
  input  logic [5:0]         ram_q,
  output logic               busy
`ifdef ARB_BOUNDS_CHECK_EN
  ,
  output logic               bound_err
`endif
);

  localparam int c_PAD = 4;
`ifdef ARB_BOUNDS_CHECK_EN
  localparam bit c_CHECK = 1'b1;
`else
  localparam bit c_CHECK = 1'b0;
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, OWN = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [7:0] burst_q, burst_d;
  logic [3:0] gnt_q, gnt_d;

  logic [READ_LATENCY-1:0] pv_q;
  logic [READ_LATENCY-1:0] pz_q;
  logic [1:0]              pi_q [READ_LATENCY];

  // Requester slots padded to four so a 2-bit owner index is always in range.
  logic [3:0] w_req, w_lock, w_wren;
  logic [7:0] w_addr  [c_PAD];
  logic [5:0] w_wdata [c_PAD];

  for (genvar gi = 0; gi < c_PAD; gi++) begin : g_pad
    if (gi < N_REQ) begin : g_live
      assign w_req[gi]   = req[gi];
      assign w_lock[gi]  = lock[gi];
      assign w_wren[gi]  = wren[gi];
      assign w_addr[gi]  = addr[8*gi +: 8];
      assign w_wdata[gi] = wdata[6*gi +: 6];
    end else begin : g_tie
      assign w_req[gi]   = 1'b0;
      assign w_lock[gi]  = 1'b0;
      assign w_wren[gi]  = 1'b0;
      assign w_addr[gi]  = 8'd0;
      assign w_wdata[gi] = 6'd0;
    end
  end

  logic       w_access, w_others, w_preempt, w_oob, w_pick_vld;
  logic [1:0] w_pick, w_ptr_nxt;
  logic [2:0] w_idx;

  assign w_access  = (state_q == OWN) && w_req[owner_q];
  assign w_others  = |(w_req & ~(4'b0001 << owner_q));
  assign w_preempt = w_access && !w_lock[owner_q] && (int'(burst_q) >= MAX_BURST) && w_others;
  assign w_oob     = c_CHECK && w_access && (int'(w_addr[owner_q]) >= BOARD_CELLS);
  assign w_ptr_nxt = (owner_q == 2'(N_REQ-1)) ? 2'd0 : owner_q + 2'd1;

  // Scan from the farthest slot back to the pointer so the nearest requester wins.
  always_comb begin
    w_pick     = 2'd0;
    w_pick_vld = 1'b0;
    w_idx      = 3'd0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      w_idx = {1'b0, ptr_q} + 3'(k);
      if (w_idx >= 3'(N_REQ)) w_idx = w_idx - 3'(N_REQ);
      if (w_req[w_idx[1:0]]) begin
        w_pick     = w_idx[1:0];
        w_pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    burst_d = burst_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (w_pick_vld) begin
          state_d = OWN;
          owner_d = w_pick;
          gnt_d   = 4'b0001 << w_pick;
          burst_d = 8'd1;
        end
      end
      OWN: begin
        if (!w_req[owner_q] || w_preempt) begin
          state_d = IDLE;
          gnt_d   = 4'd0;
          ptr_d   = w_ptr_nxt;
        end else if (burst_q != 8'hFF) begin
          burst_d = burst_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      burst_q <= 8'd0;
      gnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      gnt_q   <= gnt_d;
    end
  end

  // Read-return pipeline: one slot per cycle of RAM latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv_q <= '0;
      pz_q <= '0;
      for (int s = 0; s < READ_LATENCY; s++) pi_q[s] <= 2'd0;
    end else begin
      pv_q[0] <= w_access && !w_wren[owner_q];
      pz_q[0] <= w_oob;
      pi_q[0] <= owner_q;
      for (int s = 1; s < READ_LATENCY; s++) begin
        pv_q[s] <= pv_q[s-1];
        pz_q[s] <= pz_q[s-1];
        pi_q[s] <= pi_q[s-1];
      end
    end
  end

  for (genvar gr = 0; gr < N_REQ; gr++) begin : g_rv
    assign rvalid[gr] = pv_q[READ_LATENCY-1] && (pi_q[READ_LATENCY-1] == 2'(gr));
  end

  assign rdata = (pv_q[READ_LATENCY-1] && pz_q[READ_LATENCY-1]) ? 6'd0 : ram_q;

  always_comb begin
    ram_addr = 8'd0;
    ram_data = 6'd0;
    ram_wren = 1'b0;
    if (state_q == OWN) begin
      ram_addr = w_oob ? 8'd0 : w_addr[owner_q];
      ram_data = w_wdata[owner_q];
      ram_wren = w_access && w_wren[owner_q] && !w_oob;
    end
  end

  assign gnt  = gnt_q[N_REQ-1:0];
  assign busy = (state_q == OWN);

`ifdef ARB_BOUNDS_CHECK_EN
  assign bound_err = w_oob;
`endif

endmodule
`default_nettype wire

// File: tb/tb_board_ram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_board_ram_arbiter : directed + random stimulus against a transaction model
// Rev 1.0
// ============================================================================
module tb_board_ram_arbiter;

  localparam int N     = 4;
  localparam int L     = 2;
  localparam int MB    = 4;
  localparam int CELLS = 200;
`ifdef ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic [N-1:0]   req = '0, lock = '0, wren = '0;
  logic [8*N-1:0] addr = '0;
  logic [6*N-1:0] wdata = '0;
  logic [5:0]     ram_q = '0;
  logic [N-1:0]   gnt, rvalid;
  logic [5:0]     rdata, ram_data;
  logic [7:0]     ram_addr;
  logic           ram_wren, busy;
`ifdef ARB_BOUNDS_CHECK_EN
  logic           bound_err;
`endif

  always #5 clk = ~clk;

  board_ram_arbiter #(
    .N_REQ(N), .READ_LATENCY(L), .MAX_BURST(MB), .BOARD_CELLS(CELLS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .addr(addr),
    .wdata(wdata), .wren(wren), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .busy(busy)
`ifdef ARB_BOUNDS_CHECK_EN
    , .bound_err(bound_err)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: who owns the RAM, where the pointer is, and reads waiting to return.
  typedef struct {int rem; int idx; bit oob;} rd_t;
  int  m_owner = -1;
  int  m_ptr   = 0;
  int  m_burst = 0;
  rd_t rq[$];

  int gnt_cyc[N];
  int rv_cnt[N];
  int berr_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      gnt_cyc[i] = 0;
      rv_cnt[i]  = 0;
    end
    berr_cnt = 0;
  endtask

  task automatic cycle();
    logic [N-1:0] e_gnt, e_rv;
    logic [7:0]   a, e_addr;
    logic [5:0]   e_data, e_rdata;
    logic         e_wren, e_busy, oob, others, found;
    rd_t          nq[$];
    rd_t          ent;
    ram_q = 6'($urandom);
    @(negedge clk);
    e_gnt = '0; e_rv = '0; e_addr = '0; e_data = '0; e_wren = 1'b0; oob = 1'b0;
    e_rdata = ram_q;
    e_busy = (m_owner >= 0);
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      a      = addr[8*m_owner +: 8];
      oob    = BOUNDS && req[m_owner] && (int'(a) >= CELLS);
      e_addr = oob ? 8'd0 : a;
      e_data = wdata[6*m_owner +: 6];
      e_wren = req[m_owner] && wren[m_owner] && !oob;
    end
    foreach (rq[k]) if (rq[k].rem == 0) begin
      e_rv[rq[k].idx] = 1'b1;
      if (rq[k].oob) e_rdata = 6'd0;
    end
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("rvalid", 32'(rvalid), 32'(e_rv));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_wren", 32'(ram_wren), 32'(e_wren));
    if (m_owner >= 0) chk("ram_data", 32'(ram_data), 32'(e_data));
    if (e_rv != '0) chk("rdata", 32'(rdata), 32'(e_rdata));
`ifdef ARB_BOUNDS_CHECK_EN
    chk("bound_err", 32'(bound_err), 32'(oob));
    if (bound_err) berr_cnt++;
`endif
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_cyc[i]++;
      if (rvalid[i]) rv_cnt[i]++;
    end
    // advance the model by one clock
    foreach (rq[k]) if (rq[k].rem > 0) begin
      ent = rq[k];
      ent.rem--;
      nq.push_back(ent);
    end
    rq = nq;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % N;
          m_burst = 1;
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      if (!wren[m_owner]) begin
        ent.rem = L - 1; ent.idx = m_owner; ent.oob = oob;
        rq.push_back(ent);
      end
      others = 1'b0;
      for (int j = 0; j < N; j++) if (j != m_owner && req[j]) others = 1'b1;
      if (!lock[m_owner] && m_burst >= MB && others) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_burst = (m_burst < 255) ? m_burst + 1 : 255;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; lock = '0; wren = '0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    m_owner = -1; m_ptr = 0; m_burst = 0;
    rq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset and single requester reading address 37
    do_reset();
    clear_counts();
    req = 4'b0010; addr[15:8] = 8'd37;
    repeat (4) cycle();
    req = '0;
    repeat (3) cycle();
    chk("single_rv_count", 32'(rv_cnt[1]), 32'd3);
    chk("single_gnt_len", 32'(gnt_cyc[1]), 32'd4);

    // contention: 0 and 2 together from pointer 0
    do_reset();
    req = 4'b0101; wren = 4'b0100;
    addr[7:0] = 8'd5; addr[23:16] = 8'd150; wdata[17:12] = 6'h2A;
    repeat (4) cycle();
    req[0] = 1'b0;
    repeat (2) cycle();
    chk("contend_gnt2", 32'(gnt), 32'b0100);
    repeat (3) cycle();
    req[2] = 1'b0;
    cycle();
    req = 4'b1001;
    cycle();
    chk("contend_ptr3", 32'(gnt), 32'b1000);
    req = '0;
    repeat (3) cycle();

    // preemption of an unlocked owner
    do_reset();
    clear_counts();
    req = 4'b1000; wren = '0; addr[31:24] = 8'd77; addr[15:8] = 8'd12;
    repeat (2) cycle();
    req[1] = 1'b1;
    repeat (3) cycle();
    chk("preempt_g3_len", 32'(gnt_cyc[3]), 32'd4);
    cycle();
    chk("preempt_gnt1", 32'(gnt), 32'b0010);
    req = '0;
    repeat (3) cycle();

    // locked owner is never preempted
    do_reset();
    clear_counts();
    req = 4'b1000; lock = 4'b1000;
    repeat (2) cycle();
    req[1] = 1'b1;
    repeat (19) cycle();
    chk("lock_g3_len", 32'(gnt_cyc[3]), 32'd20);
    chk("lock_g1_len", 32'(gnt_cyc[1]), 32'd0);
    req[3] = 1'b0;
    repeat (2) cycle();
    chk("lock_gnt1", 32'(gnt), 32'b0010);
    req = '0; lock = '0;
    repeat (3) cycle();

    // reset one cycle after a read is issued
    do_reset();
    clear_counts();
    req = 4'b0100; wren = '0; addr[23:16] = 8'd99;
    repeat (2) cycle();
    do_reset();
    repeat (4) cycle();
    chk("rstread_no_rv", 32'(rv_cnt[2]), 32'd0);

`ifdef ARB_BOUNDS_CHECK_EN
    do_reset();
    clear_counts();
    req = 4'b0001; wren = 4'b0001; addr[7:0] = 8'd200;
    repeat (2) cycle();
    addr[7:0] = 8'd199;
    cycle();
    wren = '0; addr[7:0] = 8'd250;
    cycle();
    req = '0;
    repeat (3) cycle();
    chk("bounds_err_count", 32'(berr_cnt), 32'd2);
`endif

    // random traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < N; j++) begin
        if ($urandom_range(3) == 0) req[j] = ~req[j];
        lock[j] = ($urandom_range(5) == 0);
        wren[j] = 1'($urandom_range(1));
        addr[8*j +: 8]  = 8'($urandom_range(255));
        wdata[6*j +: 6] = 6'($urandom);
      end
      cycle();
    end
    req = '0; lock = '0;
    repeat (L + 3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
